// File: rtl/led_pattern_gen.sv
// led_pattern_gen: WIDTH-bit LED pattern generator with a programmable timebase.
//
// Patterns, selected by mode:
//   0 Johnson   - twisted-ring shift, period 2*WIDTH, seed 0
//   1 binary    - up counter modulo 2^WIDTH, seed 0
//   2 ring      - one-hot rotate right, period WIDTH, seed MSB
//   3 ping-pong - one-hot bounce between ends, period 2*(WIDTH-1), seed LSB
//
// The pattern advances once per timebase period of rate+1 cycles.
//
// Optional feature macro: LED_PATTERN_PINGPONG_EN
//   defined   - mode 3 is ping-pong (direction register and bounce logic present)
//   undefined - mode 3 behaves exactly as mode 2 (ring)
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   mode   in  pattern select
//   rate   in  tick period minus one
//   hold   in  freeze pattern and timebase while high
//   q_led  out registered pattern output
//   tick   out registered strobe, high in the cycle q_led shows a newly advanced value
module led_pattern_gen #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned PRESCALE_BITS = 23
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic [PRESCALE_BITS-1:0] rate,
    input  logic                     hold,
    output logic [WIDTH-1:0]         q_led,
    output logic                     tick
);

    typedef enum logic [1:0] {
        ModeJohnson  = 2'd0,
        ModeBinary   = 2'd1,
        ModeRing     = 2'd2,
        ModePingPong = 2'd3
    } mode_e;

`ifdef LED_PATTERN_PINGPONG_EN
    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    dir_e dir_q;
    dir_e dir_adv;
`endif

    mode_e                    mode_eff;
    mode_e                    mode_q;
    logic [PRESCALE_BITS-1:0] cnt_q;
    logic [WIDTH-1:0]         seed;
    logic [WIDTH-1:0]         q_adv;

    // Without ping-pong support mode 3 is folded onto ring before it is registered, so a
    // 2<->3 switch is not a mode change and behaves identically to staying in ring.
    always_comb begin
`ifdef LED_PATTERN_PINGPONG_EN
        mode_eff = mode_e'(mode);
`else
        mode_eff = (mode == 2'd3) ? ModeRing : mode_e'(mode);
`endif
    end

    // Seed for the mode being loaded (reset or mode change).
    always_comb begin
        seed = '0;
        case (mode_eff)
            ModeRing:     seed[WIDTH-1] = 1'b1;
`ifdef LED_PATTERN_PINGPONG_EN
            ModePingPong: seed[0] = 1'b1;
`endif
            default:      seed = '0;
        endcase
    end

    // Next pattern value for an advance in the currently registered mode.
    always_comb begin
        q_adv = q_led;
`ifdef LED_PATTERN_PINGPONG_EN
        dir_adv = dir_q;
`endif
        case (mode_q)
            ModeJohnson: q_adv = {~q_led[0], q_led[WIDTH-1:1]};
            ModeBinary:  q_adv = q_led + WIDTH'(1);
`ifdef LED_PATTERN_PINGPONG_EN
            ModePingPong: begin
                // Bounce when the lit bit reaches the end it is travelling toward.
                if (dir_q == DirUp) begin
                    if (q_led[WIDTH-1]) begin
                        dir_adv = DirDown;
                        q_adv   = q_led >> 1;
                    end else begin
                        q_adv = q_led << 1;
                    end
                end else begin
                    if (q_led[0]) begin
                        dir_adv = DirUp;
                        q_adv   = q_led << 1;
                    end else begin
                        q_adv = q_led >> 1;
                    end
                end
            end
`endif
            default:     q_adv = {q_led[0], q_led[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= mode_eff;
            q_led  <= seed;
            tick   <= 1'b0;
            cnt_q  <= '0;
`ifdef LED_PATTERN_PINGPONG_EN
            dir_q  <= DirUp;
`endif
        end else begin
            mode_q <= mode_eff;
            if (mode_eff != mode_q) begin
                // Mode change outranks hold and any pending advance.
                q_led <= seed;
                tick  <= 1'b0;
                cnt_q <= '0;
`ifdef LED_PATTERN_PINGPONG_EN
                dir_q <= DirUp;
`endif
            end else if (hold) begin
                tick <= 1'b0;
            end else if (cnt_q >= rate) begin
                // >= so that lowering rate below cnt advances at once instead of wrapping.
                q_led <= q_adv;
                tick  <= 1'b1;
                cnt_q <= '0;
`ifdef LED_PATTERN_PINGPONG_EN
                dir_q <= dir_adv;
`endif
            end else begin
                tick  <= 1'b0;
                cnt_q <= cnt_q + PRESCALE_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (WIDTH=8, PRESCALE_BITS=23).
// Table-driven per-cycle vectors for Johnson and mode switching, plus hand-written
// sequences for binary wrap, ping-pong/ring, hold, rate change and mid-run reset.
module tb_led_pattern_gen;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned PB    = 23;

    logic             clk;
    logic             reset;
    logic [1:0]       mode;
    logic [PB-1:0]    rate;
    logic             hold;
    logic [WIDTH-1:0] q_led;
    logic             tick;

    int checks = 0;
    int errors = 0;

    led_pattern_gen #(
        .WIDTH         (WIDTH),
        .PRESCALE_BITS (PB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .rate  (rate),
        .hold  (hold),
        .q_led (q_led),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [1:0]    md;
        logic [PB-1:0] rt;
        logic          hd;
        logic [7:0]    exp_q;
        logic          exp_t;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic r, input logic [1:0] m, input int rt,
                                    input logic h, input logic [7:0] eq, input logic et);
        vec_t v;
        v.rst   = r;
        v.md    = m;
        v.rt    = PB'(rt);
        v.hd    = h;
        v.exp_q = eq;
        v.exp_t = et;
        vecs.push_back(v);
    endfunction

    // Drive inputs, take one rising edge, sample 1 ns later.
    task automatic step(input logic r, input logic [1:0] m, input int rt, input logic h);
        reset = r;
        mode  = m;
        rate  = PB'(rt);
        hold  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] eq,
                         input logic et);
        checks++;
        if (q_led !== eq || tick !== et) begin
            errors++;
            $display("FAIL %s[%0d]: got q_led=%h tick=%b, expected q_led=%h tick=%b",
                     name, idx, q_led, tick, eq, et);
        end
    endtask

    logic [7:0] jseq [16] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                              8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    logic [7:0] pseq [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] rseq [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};

    initial begin
        reset = 1'b1;
        mode  = 2'd0;
        rate  = '0;
        hold  = 1'b0;

        // Johnson, rate 0: seed 00 then full 16-step period, tick high every cycle.
        add_vec(1'b1, 2'd0, 0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 16; k++) add_vec(1'b0, 2'd0, 0, 1'b0, jseq[k], 1'b1);
        add_vec(1'b0, 2'd0, 0, 1'b0, 8'h80, 1'b1);

        // Johnson at rate 9 for 22 edges, then switch to ring: seed 80 one cycle later
        // with no tick, next advance 10 edges after that.
        add_vec(1'b1, 2'd0, 9, 1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= 22; k++) begin
            if (k < 10)       add_vec(1'b0, 2'd0, 9, 1'b0, 8'h00, 1'b0);
            else if (k == 10) add_vec(1'b0, 2'd0, 9, 1'b0, 8'h80, 1'b1);
            else if (k < 20)  add_vec(1'b0, 2'd0, 9, 1'b0, 8'h80, 1'b0);
            else if (k == 20) add_vec(1'b0, 2'd0, 9, 1'b0, 8'hC0, 1'b1);
            else              add_vec(1'b0, 2'd0, 9, 1'b0, 8'hC0, 1'b0);
        end
        add_vec(1'b0, 2'd2, 9, 1'b0, 8'h80, 1'b0);
        for (int k = 0; k < 9; k++) add_vec(1'b0, 2'd2, 9, 1'b0, 8'h80, 1'b0);
        add_vec(1'b0, 2'd2, 9, 1'b0, 8'h40, 1'b1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].md, int'(vecs[i].rt), vecs[i].hd);
            check("table", i, vecs[i].exp_q, vecs[i].exp_t);
        end

        // Binary, rate 3: +1 every 4 cycles, single-cycle tick, FF->00 wrap at cycle 1024.
        step(1'b1, 2'd1, 3, 1'b0);
        check("bin_reset", 0, 8'h00, 1'b0);
        for (int k = 1; k <= 1030; k++) begin
            step(1'b0, 2'd1, 3, 1'b0);
            check("binary", k, 8'((k / 4) % 256), (k % 4) == 0);
        end

        // Mode 3, rate 0: ping-pong when enabled, otherwise identical to ring.
        step(1'b1, 2'd3, 0, 1'b0);
`ifdef LED_PATTERN_PINGPONG_EN
        check("pp_reset", 0, 8'h01, 1'b0);
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 2'd3, 0, 1'b0);
            check("pingpong", k, pseq[k % 14], 1'b1);
        end
`else
        check("pp_reset", 0, 8'h80, 1'b0);
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 2'd3, 0, 1'b0);
            check("mode3_ring", k, rseq[k % 8], 1'b1);
        end
        if (pseq[0] == 8'h00) $display("unreachable");
`endif

        // Ring, rate 5, hold for 20 cycles with cnt frozen at 2.
        step(1'b1, 2'd2, 5, 1'b0);
        check("hold_reset", 0, 8'h80, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 2'd2, 5, 1'b0);
            check("hold_pre", k, 8'h80, 1'b0);
        end
        step(1'b0, 2'd2, 5, 1'b0);
        check("hold_adv", 0, 8'h40, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 2'd2, 5, 1'b0);
            check("hold_cnt", k, 8'h40, 1'b0);
        end
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 2'd2, 5, 1'b1);
            check("hold_frozen", k, 8'h40, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'd2, 5, 1'b0);
            check("hold_resume", k, 8'h40, 1'b0);
        end
        step(1'b0, 2'd2, 5, 1'b0);
        check("hold_next_adv", 0, 8'h20, 1'b1);

        // Mode change outranks hold.
        step(1'b0, 2'd1, 5, 1'b1);
        check("mode_over_hold", 0, 8'h00, 1'b0);

        // Rate lowered below cnt: advance on the very next edge.
        step(1'b1, 2'd2, 20, 1'b0);
        check("rate_reset", 0, 8'h80, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 2'd2, 20, 1'b0);
            check("rate_pre", k, 8'h80, 1'b0);
        end
        step(1'b0, 2'd2, 2, 1'b0);
        check("rate_drop", 0, 8'h40, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 2'd2, 2, 1'b0);
            check("rate_after", k, 8'h40, 1'b0);
        end
        step(1'b0, 2'd2, 2, 1'b0);
        check("rate_next", 0, 8'h20, 1'b1);

        // Mid-run reset while ticking continuously.
        step(1'b0, 2'd2, 0, 1'b0);
        check("mid_run", 0, 8'h10, 1'b1);
        step(1'b0, 2'd2, 0, 1'b0);
        check("mid_run", 1, 8'h08, 1'b1);
        step(1'b1, 2'd2, 0, 1'b0);
        check("mid_reset", 0, 8'h80, 1'b0);
        step(1'b0, 2'd2, 0, 1'b0);
        check("post_reset", 0, 8'h40, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
